// File: rtl/md5_block_padder_if.sv
// Byte-stream input and padded-block output bundle for md5_block_padder.
// The slave modport is the padder's view; master is the producer/consumer side.
interface md5_block_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         out_error;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_block, out_error
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_block, out_error
    );
endinterface

// File: rtl/md5_block_padder.sv
// Packs a 1..55 byte message little-endian into one 512-bit MD5 block with
// 0x80 pad byte, zero fill and 64-bit bit length; oversize messages are dropped.
module md5_block_padder #(
    parameter int WORD_BITS = 32,
    parameter int MAX_BYTES = 55
) (
    input  logic                 clk,
    input  logic                 reset,
    md5_block_padder_if.slave    bus
);
    localparam int          BLOCK_BITS = 16 * WORD_BITS;
    localparam logic [5:0]  MAX_N      = 6'(MAX_BYTES);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [5:0]              n_r, n_nxt_s, n_p1_s;
    logic [BLOCK_BITS-1:0]   block_r, block_nxt_s;
    logic                    error_r, error_nxt_s;
    logic                    in_ready_r, out_valid_r;
    logic                    accept_s;
    logic [WORD_BITS-1:0]    len_bits_s;

    assign accept_s   = bus.in_valid && in_ready_r;
    assign n_p1_s     = n_r + 6'd1;
    assign len_bits_s = {23'd0, n_p1_s, 3'b000};

    // Next-state, byte packing and padding decisions.
    always_comb begin
        state_nxt_s = state_r;
        n_nxt_s     = n_r;
        block_nxt_s = block_r;
        error_nxt_s = 1'b0;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (n_r == MAX_N) begin
                        // 56th byte: message cannot fit, flag it and discard the rest.
                        block_nxt_s = {BLOCK_BITS{1'b0}};
                        n_nxt_s     = 6'd0;
                        error_nxt_s = 1'b1;
                        if (bus.in_last) begin
                            state_nxt_s = COLLECT;
                        end else begin
                            state_nxt_s = DRAIN;
                        end
                    end else begin
                        block_nxt_s[{n_r, 3'b000} +: 8] = bus.in_data;
                        n_nxt_s = n_p1_s;
                        if (bus.in_last) begin
                            block_nxt_s[{n_p1_s, 3'b000} +: 8]        = 8'h80;
                            block_nxt_s[14*WORD_BITS +: WORD_BITS]    = len_bits_s;
                            block_nxt_s[15*WORD_BITS +: WORD_BITS]    = {WORD_BITS{1'b0}};
                            state_nxt_s = EMIT;
                        end else begin
                            state_nxt_s = COLLECT;
                        end
                    end
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            DRAIN: begin
                if (accept_s && bus.in_last) begin
                    n_nxt_s     = 6'd0;
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    block_nxt_s = {BLOCK_BITS{1'b0}};
                    n_nxt_s     = 6'd0;
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: begin
                block_nxt_s = {BLOCK_BITS{1'b0}};
                n_nxt_s     = 6'd0;
                state_nxt_s = COLLECT;
            end
        endcase
    end

    // State, counter, block and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= COLLECT;
            n_r         <= 6'd0;
            block_r     <= {BLOCK_BITS{1'b0}};
            error_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            n_r         <= n_nxt_s;
            block_r     <= block_nxt_s;
            error_r     <= error_nxt_s;
            in_ready_r  <= (state_nxt_s != EMIT);
            out_valid_r <= (state_nxt_s == EMIT);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_block = block_r;
    assign bus.out_error = error_r;
endmodule
